// File: rtl/bw_mult_pkg.sv
// Shared types and Baugh-Wooley helpers for the sequential signed multiplier.
// The helpers work at a fixed maximum width; callers truncate to 2N bits.
package bw_mult_pkg;

    localparam int BW_MAX = 32;
    localparam int RW     = 2 * BW_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // K = 2^n + 2^(2n-1): folds the sign corrections of the inverted rows.
    function automatic logic [RW-1:0] bw_corr_const(input int n);
        logic [RW-1:0] k;
        k = (RW'(1) << n) | (RW'(1) << (2 * n - 1));
        return k;
    endfunction

    // Unshifted row: low n-1 bits are a&bbit (inverted on the last row),
    // bit n-1 carries the sign-bit product (inverted on every other row).
    function automatic logic [RW-1:0] bw_row(input logic [BW_MAX-1:0] a,
                                             input logic              bbit,
                                             input logic              last,
                                             input int                n);
        logic [BW_MAX-1:0] low_mask;
        logic [BW_MAX-1:0] pp;
        logic [BW_MAX-1:0] lo;
        logic              an;
        logic              top;
        low_mask = (BW_MAX'(1) << (n - 1)) - BW_MAX'(1);
        pp       = a & {BW_MAX{bbit}};
        lo       = (last ? ~pp : pp) & low_mask;
        an       = |(a & (BW_MAX'(1) << (n - 1)));
        top      = last ? (an & bbit) : ~(an & bbit);
        return {BW_MAX'(0), lo} | (RW'(top) << (n - 1));
    endfunction

endpackage

// File: rtl/bw_seq_mult_ctrl_if.sv
// Handshake and operand/result bundle between a requester and the multiplier.
interface bw_seq_mult_ctrl_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/bw_seq_mult_ctrl_row_gen.sv
// Combinational generator for one shifted Baugh-Wooley partial-product row.
module bw_row_gen
    import bw_mult_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]   a,
    input  logic           bbit,
    input  logic [CW-1:0]  idx,
    input  logic           last,
    output logic [2*N-1:0] row
);

    logic [RW-1:0]  row_full;
    logic [2*N-1:0] row_base;

    assign row_full = bw_row(BW_MAX'(a), bbit, last, N);
    assign row_base = row_full[2*N-1:0];
    assign row      = row_base << idx;

    // Bits above 2N are always zero for legal N; they are simply dropped.
    generate
        if (2 * N < RW) begin : g_hi
            logic unused_row_hi;
            assign unused_row_hi = ^row_full[RW-1:2*N];
        end
    endgenerate

endmodule

// File: rtl/bw_seq_mult_ctrl.sv
// Sequential signed NxN Baugh-Wooley multiplier: one partial-product row per
// clock into a shared 2N-bit accumulator, with start/busy/done handshake.
module bw_seq_mult_ctrl
    import bw_mult_pkg::*;
#(
    parameter int N = 8
) (
    input logic               clk,
    input logic               rst,
    bw_seq_mult_ctrl_if.slave bus
);

    localparam int             CW       = $clog2(N);
    localparam logic [2*N-1:0] K        = (2*N)'(bw_corr_const(N));
    localparam logic [CW-1:0]  LAST_ROW = CW'(N - 1);

    state_t         state_reg, state_next;
    logic [2*N-1:0] acc_reg, acc_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N-1:0]   a_reg, a_next;
    logic [N-1:0]   b_reg, b_next;
    logic [2*N-1:0] product_reg, product_next;

    logic           last_row;
    logic [2*N-1:0] row;
    logic [2*N-1:0] acc_sum;

    assign last_row = (cnt_reg == LAST_ROW);

    bw_row_gen #(
        .N  (N),
        .CW (CW)
    ) u_row_gen (
        .a    (a_reg),
        .bbit (b_reg[cnt_reg]),
        .idx  (cnt_reg),
        .last (last_row),
        .row  (row)
    );

    // Carry out of bit 2N-1 is discarded: the result is exact modulo 2^(2N).
    assign acc_sum = acc_reg + row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new start directly for back-to-back operation.
                if (bus.start) begin
                    a_next     = bus.a;
                    b_next     = bus.b;
                    acc_next   = K;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                acc_next = acc_sum;
                cnt_next = cnt_reg + 1'b1;
                if (last_row) begin
                    cnt_next     = '0;
                    product_next = acc_sum;
                    state_next   = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg == RUN);
    assign bus.done    = (state_reg == DONE);
    assign bus.product = product_reg;

endmodule
